axi_sram_slave: RTL and testbench
=================================

// Module: axi_sram_slave
// PURPOSE
//  AXI4 memory responder: terminates an axi_channel slave modport on an internal byte-strobed
//  register-array memory. Independent read and write engines, one outstanding burst each,
//  FIXED/INCR/WRAP bursts. Default endpoint for interconnect simulation and small on-chip scratchpads.
// PARAMETERS
//  ID_WIDTH    4       AXI ID width; must match the bound axi_channel.
//  ADDR_WIDTH  32      AXI address width.
//  DATA_WIDTH  64      data bus width; power of 2, 8..1024. STRB = DATA_WIDTH/8, OFS = $clog2(STRB).
//  MEM_DEPTH   1024    memory size in DATA_WIDTH words; power of 2.
//  BASE_ADDR   0       byte address of word 0; aligned to MEM_DEPTH*STRB.
// PORTS
//  clk   input  1          clock; all logic on rising edge.
//  rst   input  1          asynchronous, active-high reset.
//  axi   modport -         axi_channel.slave; its clk/rstn members are not used by this block.
// BEHAVIOUR
//  Reset (async, active-high): aw/w/ar_ready=0, b_valid=r_valid=0, b_resp=r_resp=OKAY, r_last=0,
//   r_data=0, ids=0, both FSMs idle. Memory contents not reset. Mid-burst reset abandons the burst;
//   already-written beats stay in memory. *_user outputs tied 0.
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   - W_IDLE: aw_ready=1; on aw handshake latch id/addr/len/size/burst, beat count=0 -> W_DATA.
//   - W_DATA: w_ready=1; each w handshake writes bytes with w_strb set to mem[idx]; advance addr.
//     On beat count==len -> W_RESP. Any beat where w_last != (count==len) sets sticky SLVERR.
//   - W_RESP: b_valid=1, b_id=latched id, b_resp=OKAY or SLVERR; hold until b_ready, then W_IDLE.
//   - aw_ready is never 1 outside W_IDLE; no W data accepted before AW.
//  Read FSM R_IDLE -> R_DATA -> R_IDLE:
//   - R_IDLE: ar_ready=1; on handshake latch fields, register r_data=mem[idx(ar_addr)] -> R_DATA.
//   - R_DATA: r_valid=1, r_id=latched id, r_last=(count==len). On r handshake: count++, advance addr,
//     register next word. After the last beat -> R_IDLE. First r_valid one cycle after ar handshake.
//   - r_data/r_resp/r_last stable while r_valid && !r_ready.
//  Address arithmetic (per engine): idx = ((addr-BASE_ADDR) >> OFS) mod MEM_DEPTH.
//   - FIXED: addr unchanged. INCR: addr = (addr & ~((1<<size)-1)) + (1<<size).
//   - WRAP: size-aligned; boundary = (len+1)<<size; addr wraps to the aligned boundary base.
//   - Errors -> SLVERR for the whole burst, writes suppressed, reads return 0, beats still counted:
//     size > OFS; WRAP with len not in {1,3,7,15}; burst==RESERVED.
//  Simultaneous events: write and read of the same word in one cycle -> read registers the old data.
//   AW and AR handshakes are independent and may coincide. Narrow writes rely on master strobes.
// CONFIGURATION
//  AXI_SRAM_BOUNDS_EN defined: any beat whose addr is outside
//   [BASE_ADDR, BASE_ADDR+MEM_DEPTH*STRB) is DECERR: write beat suppressed, read beat r_data=0,
//   r_resp=DECERR, write response DECERR (DECERR outranks SLVERR).
//  Not defined: no range check; idx aliases modulo MEM_DEPTH; out-of-range responses are OKAY.
// TESTING
//  T1 AW INCR addr 0x10 len 3 size 3, W 4 beats strb 0xFF, last on beat 4 -> b_resp OKAY; AR same
//     -> 4 beats, r_data matches, r_last on beat 4 only.
//  T2 WRAP addr 0x28 len 3 size 3 -> beats at 0x28,0x30,0x38,0x20; read back in that order.
//  T3 strb 0x0F over 0xFFFF..FF then read -> upper 4 bytes unchanged; FIXED len 3 -> 4 reads of one word.
//  T4 w_last early on beat 2 of len 3 -> b_resp SLVERR after 4 beats; AR size 4 on 64-bit bus -> 1..n SLVERR.
//  T5 r_ready held low 5 cycles while a write hits the next word -> r_data stable; later beat shows new data.
//  T6 rst asserted mid-write burst -> all valids/readies 0 same cycle; new AW accepted after release;
//     with AXI_SRAM_BOUNDS_EN, AR at BASE_ADDR+MEM_DEPTH*STRB -> DECERR, r_data=0.

Source files
------------

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 memory responder backed by a byte-strobed register array.
// Independent write (AW/W/B) and read (AR/R) engines, one outstanding burst each,
// FIXED/INCR/WRAP bursts.
// Optional feature macro: AXI_SRAM_BOUNDS_EN. When defined, beats outside
// [BASE_ADDR, BASE_ADDR+MEM_DEPTH*STRB) get DECERR; when undefined the word index
// aliases modulo MEM_DEPTH and every in-protocol beat is OKAY.
//
// Handshake rule for every channel: a transfer happens on the rising clk edge where
// valid && ready are both 1. A valid source holds its payload stable until then.
// All ready/valid outputs of this block are registered.
module axi_sram_slave #(
   parameter int                    ID_WIDTH   = 4,
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    MEM_DEPTH  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   // write address channel
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [ID_WIDTH-1:0]     aw_id,
   input  logic [ADDR_WIDTH-1:0]   aw_addr,
   input  logic [7:0]              aw_len,
   input  logic [2:0]              aw_size,
   input  logic [1:0]              aw_burst,
   // write data channel
   input  logic                    w_valid,
   output logic                    w_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb,
   input  logic                    w_last,
   // write response channel
   output logic                    b_valid,
   input  logic                    b_ready,
   output logic [ID_WIDTH-1:0]     b_id,
   output logic [1:0]              b_resp,
   output logic                    b_user,
   // read address channel
   input  logic                    ar_valid,
   output logic                    ar_ready,
   input  logic [ID_WIDTH-1:0]     ar_id,
   input  logic [ADDR_WIDTH-1:0]   ar_addr,
   input  logic [7:0]              ar_len,
   input  logic [2:0]              ar_size,
   input  logic [1:0]              ar_burst,
   // read data channel
   output logic                    r_valid,
   input  logic                    r_ready,
   output logic [ID_WIDTH-1:0]     r_id,
   output logic [DATA_WIDTH-1:0]   r_data,
   output logic [1:0]              r_resp,
   output logic                    r_last,
   output logic                    r_user,
   // FSM state visibility
   output logic [1:0]              dbg_w_state,
   output logic                    dbg_r_state
);

   localparam int STRB  = DATA_WIDTH / 8;
   localparam int OFS   = $clog2(STRB);
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
   typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

   // Word index inside the array; upper offset bits are dropped so addresses alias.
   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
      return IDX_W'((addr - BASE_ADDR) >> OFS);
   endfunction

   // Address of the beat following addr for the given burst shape.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [2:0]            size,
                                                       input logic [7:0]            len,
                                                       input logic [1:0]            burst);
      logic [ADDR_WIDTH-1:0] step;
      logic [ADDR_WIDTH-1:0] aligned;
      logic [ADDR_WIDTH-1:0] incr;
      logic [ADDR_WIDTH-1:0] wrap_mask;
      step      = ADDR_WIDTH'(1) << size;
      aligned   = addr & ~(step - ADDR_WIDTH'(1));
      incr      = aligned + step;
      // The wrap window is (len+1) transfers wide and naturally aligned.
      wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_INCR:  next_addr = incr;
         BURST_WRAP:  next_addr = (aligned & ~wrap_mask) | (incr & wrap_mask);
         default:     next_addr = addr;
      endcase
   endfunction

   // Burst shapes this memory refuses: oversize transfers, illegal wrap lengths, RESERVED.
   function automatic logic burst_bad(input logic [2:0] size,
                                      input logic [7:0] len,
                                      input logic [1:0] burst);
      logic wrap_len_ok;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      return (size > 3'(OFS)) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
   endfunction

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // write engine registers
   w_state_t              w_state;
   logic [ID_WIDTH-1:0]   w_id_q;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [7:0]            w_len;
   logic [2:0]            w_size;
   logic [1:0]            w_burst;
   logic [7:0]            w_cnt;
   logic                  w_bad;
   logic                  w_slverr;
   logic                  w_decerr;

   // read engine registers
   r_state_t              r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic [7:0]            r_cnt;
   logic                  r_bad;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic                  r_hs;
   logic                  w_last_beat;
   logic                  w_oob;
   logic                  w_slv_next;
   logic                  w_dec_next;
   logic                  mem_we;
   logic [IDX_W-1:0]      w_idx;
   logic                  ar_bad;
   logic                  ar_oob;
   logic [ADDR_WIDTH-1:0] r_nxt_addr;
   logic                  r_nxt_oob;

   assign aw_hs = aw_valid && aw_ready;
   assign w_hs  = w_valid && w_ready;
   assign ar_hs = ar_valid && ar_ready;
   assign r_hs  = r_valid && r_ready;

   assign w_last_beat = (w_cnt == w_len);
   assign w_idx       = word_idx(w_addr);
   assign ar_bad      = burst_bad(ar_size, ar_len, ar_burst);
   assign r_nxt_addr  = next_addr(r_addr, r_size, r_len, r_burst);

`ifdef AXI_SRAM_BOUNDS_EN
   localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(MEM_DEPTH * STRB);

   // True when addr falls outside the window this memory decodes.
   function automatic logic out_of_span(input logic [ADDR_WIDTH-1:0] addr);
      return (addr < BASE_ADDR) || ({1'b0, addr - BASE_ADDR} >= SPAN);
   endfunction

   assign w_oob     = out_of_span(w_addr);
   assign ar_oob    = out_of_span(ar_addr);
   assign r_nxt_oob = out_of_span(r_nxt_addr);
`else
   assign w_oob     = 1'b0;
   assign ar_oob    = 1'b0;
   assign r_nxt_oob = 1'b0;
`endif

   // Sticky error state including the beat currently being accepted.
   assign w_slv_next = w_slverr || w_bad || (w_last != w_last_beat);
   assign w_dec_next = w_decerr || w_oob;
   assign mem_we     = w_hs && !w_bad && !w_oob;

   assign b_user      = 1'b0;
   assign r_user      = 1'b0;
   assign dbg_w_state = w_state;
   assign dbg_r_state = r_state;

   // Byte-strobed memory write; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB; b++) begin
            if (w_strb[b]) mem[w_idx][b*8 +: 8] <= w_data[b*8 +: 8];
         end
      end
   end

   // Write engine: accept AW, absorb len+1 W beats, then return a single B.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_state  <= W_IDLE;
         aw_ready <= 1'b0;
         w_ready  <= 1'b0;
         b_valid  <= 1'b0;
         b_resp   <= RESP_OKAY;
         b_id     <= '0;
         w_id_q   <= '0;
         w_addr   <= '0;
         w_len    <= '0;
         w_size   <= '0;
         w_burst  <= '0;
         w_cnt    <= '0;
         w_bad    <= 1'b0;
         w_slverr <= 1'b0;
         w_decerr <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               aw_ready <= 1'b1;
               if (aw_hs) begin
                  w_id_q   <= aw_id;
                  w_addr   <= aw_addr;
                  w_len    <= aw_len;
                  w_size   <= aw_size;
                  w_burst  <= aw_burst;
                  w_cnt    <= '0;
                  w_bad    <= burst_bad(aw_size, aw_len, aw_burst);
                  w_slverr <= 1'b0;
                  w_decerr <= 1'b0;
                  aw_ready <= 1'b0;
                  w_ready  <= 1'b1;
                  w_state  <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  w_addr   <= next_addr(w_addr, w_size, w_len, w_burst);
                  w_cnt    <= w_cnt + 8'd1;
                  w_slverr <= w_slv_next;
                  w_decerr <= w_dec_next;
                  if (w_last_beat) begin
                     w_ready <= 1'b0;
                     b_valid <= 1'b1;
                     b_id    <= w_id_q;
                     b_resp  <= w_dec_next ? RESP_DECERR :
                                w_slv_next ? RESP_SLVERR : RESP_OKAY;
                     w_state <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (b_ready) begin
                  b_valid  <= 1'b0;
                  aw_ready <= 1'b1;
                  w_state  <= W_IDLE;
               end
            end
            default: begin
               aw_ready <= 1'b0;
               w_ready  <= 1'b0;
               b_valid  <= 1'b0;
               w_state  <= W_IDLE;
            end
         endcase
      end
   end

   // Read engine: accept AR, prefetch the first word, then advance one word per R handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= R_IDLE;
         ar_ready <= 1'b0;
         r_valid  <= 1'b0;
         r_id     <= '0;
         r_data   <= '0;
         r_resp   <= RESP_OKAY;
         r_last   <= 1'b0;
         r_addr   <= '0;
         r_len    <= '0;
         r_size   <= '0;
         r_burst  <= '0;
         r_cnt    <= '0;
         r_bad    <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               ar_ready <= 1'b1;
               if (ar_hs) begin
                  r_id     <= ar_id;
                  r_addr   <= ar_addr;
                  r_len    <= ar_len;
                  r_size   <= ar_size;
                  r_burst  <= ar_burst;
                  r_cnt    <= '0;
                  r_bad    <= ar_bad;
                  // Non-blocking read: a same-edge write to this word is not yet visible.
                  r_data   <= (ar_bad || ar_oob) ? '0 : mem[word_idx(ar_addr)];
                  r_resp   <= ar_oob ? RESP_DECERR : ar_bad ? RESP_SLVERR : RESP_OKAY;
                  r_last   <= (ar_len == 8'd0);
                  r_valid  <= 1'b1;
                  ar_ready <= 1'b0;
                  r_state  <= R_DATA;
               end
            end
            R_DATA: begin
               if (r_hs) begin
                  if (r_last) begin
                     r_valid  <= 1'b0;
                     r_last   <= 1'b0;
                     ar_ready <= 1'b1;
                     r_state  <= R_IDLE;
                  end else begin
                     r_addr <= r_nxt_addr;
                     r_cnt  <= r_cnt + 8'd1;
                     r_data <= (r_bad || r_nxt_oob) ? '0 : mem[word_idx(r_nxt_addr)];
                     r_resp <= r_nxt_oob ? RESP_DECERR : r_bad ? RESP_SLVERR : RESP_OKAY;
                     r_last <= ((r_cnt + 8'd1) == r_len);
                  end
               end
            end
            default: begin
               ar_ready <= 1'b0;
               r_valid  <= 1'b0;
               r_state  <= R_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave (64-bit data, 1024 words, BASE_ADDR 0).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axi_sram_slave;

   localparam logic [1:0] FIXED = 2'b00;
   localparam logic [1:0] INCR  = 2'b01;
   localparam logic [1:0] WRAP  = 2'b10;
   localparam logic [1:0] RSVD  = 2'b11;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;
   localparam int BUDGET = 50;

   logic        clk = 1'b0;
   logic        rst;
   logic        aw_valid, aw_ready;
   logic [3:0]  aw_id;
   logic [31:0] aw_addr;
   logic [7:0]  aw_len;
   logic [2:0]  aw_size;
   logic [1:0]  aw_burst;
   logic        w_valid, w_ready;
   logic [63:0] w_data;
   logic [7:0]  w_strb;
   logic        w_last;
   logic        b_valid, b_ready;
   logic [3:0]  b_id;
   logic [1:0]  b_resp;
   logic        b_user;
   logic        ar_valid, ar_ready;
   logic [3:0]  ar_id;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic        r_valid, r_ready;
   logic [3:0]  r_id;
   logic [63:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;
   logic        r_user;
   logic [1:0]  dbg_w_state;
   logic        dbg_r_state;

   always #5 clk = ~clk;

   axi_sram_slave dut (
      .clk(clk), .rst(rst),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
      .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
      .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp), .b_user(b_user),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
      .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
      .r_last(r_last), .r_user(r_user),
      .dbg_w_state(dbg_w_state), .dbg_r_state(dbg_r_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] wdat [16];
   logic [7:0]  wstb [16];
   logic [63:0] rdat [16];
   logic [1:0]  rresp [16];
   logic        rlast [16];
   logic [3:0]  rid [16];
   logic [1:0]  bresp;
   logic [3:0]  bid;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
      int t;
      aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id;
      t = 0;
      while (!aw_ready && t < BUDGET) begin @(negedge clk); t++; end
      check("aw_ready_seen", aw_ready, 1);
      @(negedge clk);
      aw_valid = 1'b0;
   endtask

   task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
      int t;
      w_valid = 1'b1; w_data = data; w_strb = strb; w_last = last;
      t = 0;
      while (!w_ready && t < BUDGET) begin @(negedge clk); t++; end
      check("w_ready_seen", w_ready, 1);
      @(negedge clk);
      w_valid = 1'b0; w_last = 1'b0;
   endtask

   task automatic wait_b();
      int t;
      t = 0;
      while (!b_valid && t < BUDGET) begin @(negedge clk); t++; end
      check("b_valid_seen", b_valid, 1);
      bresp = b_resp;
      bid   = b_id;
      @(negedge clk);
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int last_at);
      send_aw(addr, len, size, burst, id);
      for (int i = 0; i <= int'(len); i++) send_w(wdat[i], wstb[i], i == last_at);
      wait_b();
   endtask

   task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
      int t;
      ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id;
      t = 0;
      while (!ar_ready && t < BUDGET) begin @(negedge clk); t++; end
      check("ar_ready_seen", ar_ready, 1);
      @(negedge clk);
      ar_valid = 1'b0;
   endtask

   task automatic recv_r(input logic [7:0] len);
      int t;
      for (int i = 0; i <= int'(len); i++) begin
         t = 0;
         while (!r_valid && t < BUDGET) begin @(negedge clk); t++; end
         check("r_valid_seen", r_valid, 1);
         rdat[i] = r_data; rresp[i] = r_resp; rlast[i] = r_last; rid[i] = r_id;
         @(negedge clk);
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
      send_ar(addr, len, size, burst, id);
      check("r_first_latency", r_valid, 1);
      recv_r(len);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] exp_beats [4];
      rst = 1'b1;
      aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
      w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 1'b1;
      ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
      r_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin wdat[i] = '0; wstb[i] = 8'hFF; end
      repeat (3) @(negedge clk);

      // reset state
      check("rst_aw_ready", aw_ready, 0);
      check("rst_w_ready", w_ready, 0);
      check("rst_ar_ready", ar_ready, 0);
      check("rst_b_valid", b_valid, 0);
      check("rst_r_valid", r_valid, 0);
      check("rst_r_data", r_data, 0);
      check("rst_r_last", r_last, 0);
      check("rst_resps", {b_resp, r_resp}, 0);
      check("rst_ids", {b_id, r_id}, 0);
      check("rst_user", {b_user, r_user}, 0);
      check("rst_states", {dbg_w_state, dbg_r_state}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_aw_ready", aw_ready, 1);
      check("idle_ar_ready", ar_ready, 1);

      // T1: INCR write/read of four words at 0x10
      wdat[0] = 64'h1111_2222_3333_4444; wdat[1] = 64'h5555_6666_7777_8888;
      wdat[2] = 64'h9999_AAAA_BBBB_CCCC; wdat[3] = 64'hDDDD_EEEE_FFFF_0001;
      axi_write(32'h10, 8'd3, 3'd3, INCR, 4'h5, 3);
      check("t1_b_resp", bresp, OKAY);
      check("t1_b_id", bid, 4'h5);
      axi_read(32'h10, 8'd3, 3'd3, INCR, 4'h6);
      check("t1_r0", rdat[0], 64'h1111_2222_3333_4444);
      check("t1_r1", rdat[1], 64'h5555_6666_7777_8888);
      check("t1_r2", rdat[2], 64'h9999_AAAA_BBBB_CCCC);
      check("t1_r3", rdat[3], 64'hDDDD_EEEE_FFFF_0001);
      check("t1_last", {rlast[0], rlast[1], rlast[2], rlast[3]}, 4'b0001);
      check("t1_rid", rid[3], 4'h6);
      check("t1_rresp", {rresp[0], rresp[1], rresp[2], rresp[3]}, 8'h00);

      // T2: WRAP at 0x28 touches 0x28,0x30,0x38,0x20
      wdat[0] = 64'hB000_0000_0000_0028; wdat[1] = 64'hB000_0000_0000_0030;
      wdat[2] = 64'hB000_0000_0000_0038; wdat[3] = 64'hB000_0000_0000_0020;
      axi_write(32'h28, 8'd3, 3'd3, WRAP, 4'h2, 3);
      check("t2_b_resp", bresp, OKAY);
      axi_read(32'h28, 8'd3, 3'd3, WRAP, 4'h3);
      check("t2_wrap_r0", rdat[0], 64'hB000_0000_0000_0028);
      check("t2_wrap_r3", rdat[3], 64'hB000_0000_0000_0020);
      check("t2_wrap_last", {rlast[0], rlast[1], rlast[2], rlast[3]}, 4'b0001);
      axi_read(32'h20, 8'd3, 3'd3, INCR, 4'h3);
      exp_beats[0] = 64'hB000_0000_0000_0020; exp_beats[1] = 64'hB000_0000_0000_0028;
      exp_beats[2] = 64'hB000_0000_0000_0030; exp_beats[3] = 64'hB000_0000_0000_0038;
      for (int i = 0; i < 4; i++) check($sformatf("t2_incr_r%0d", i), rdat[i], exp_beats[i]);

      // T3: partial strobes, then FIXED bursts
      wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstb[0] = 8'hFF;
      axi_write(32'h100, 8'd0, 3'd3, INCR, 4'h1, 0);
      wdat[0] = 64'h0123_4567_89AB_CDEF; wstb[0] = 8'h0F;
      axi_write(32'h100, 8'd0, 3'd3, INCR, 4'h1, 0);
      check("t3_strb_b_resp", bresp, OKAY);
      wstb[0] = 8'hFF;
      axi_read(32'h100, 8'd3, 3'd3, FIXED, 4'h1);
      for (int i = 0; i < 4; i++) check($sformatf("t3_fixed_r%0d", i), rdat[i], 64'hFFFF_FFFF_89AB_CDEF);
      check("t3_fixed_last", {rlast[0], rlast[1], rlast[2], rlast[3]}, 4'b0001);
      wdat[0] = 64'hC0; wdat[1] = 64'hC1; wdat[2] = 64'hC2;
      axi_write(32'h108, 8'd2, 3'd3, FIXED, 4'h1, 2);
      axi_read(32'h108, 8'd0, 3'd3, INCR, 4'h1);
      check("t3_fixed_write", rdat[0], 64'hC2);

      // T4: protocol and shape errors
      wdat[0] = 64'h40; wdat[1] = 64'h41; wdat[2] = 64'h42; wdat[3] = 64'h43;
      axi_write(32'h200, 8'd3, 3'd3, INCR, 4'h7, 1);
      check("t4_early_last_resp", bresp, SLVERR);
      check("t4_early_last_id", bid, 4'h7);
      axi_read(32'h10, 8'd1, 3'd4, INCR, 4'h8);
      check("t4_size_resp", {rresp[0], rresp[1]}, {SLVERR, SLVERR});
      check("t4_size_data", rdat[0] | rdat[1], 64'h0);
      check("t4_size_last", {rlast[0], rlast[1]}, 2'b01);
      wdat[0] = 64'h5555_5555_5555_5555;
      axi_write(32'h300, 8'd0, 3'd3, INCR, 4'h1, 0);
      wdat[0] = 64'hDEAD_0000_0000_0000; wdat[1] = 64'hDEAD_0000_0000_0001; wdat[2] = 64'hDEAD_0000_0000_0002;
      axi_write(32'h300, 8'd2, 3'd3, WRAP, 4'h1, 2);
      check("t4_wrap_len_resp", bresp, SLVERR);
      axi_read(32'h300, 8'd0, 3'd3, INCR, 4'h1);
      check("t4_wrap_suppressed", rdat[0], 64'h5555_5555_5555_5555);
      check("t4_wrap_read_resp", rresp[0], OKAY);
      axi_read(32'h300, 8'd0, 3'd3, RSVD, 4'h1);
      check("t4_rsvd_resp", rresp[0], SLVERR);
      check("t4_rsvd_data", rdat[0], 64'h0);

      // T5: back-pressured read while the next word is rewritten
      wdat[0] = 64'hAAAA_0000_0000_0400;
      axi_write(32'h400, 8'd0, 3'd3, INCR, 4'h1, 0);
      wdat[0] = 64'hBBBB_0000_0000_0408;
      axi_write(32'h408, 8'd0, 3'd3, INCR, 4'h1, 0);
      r_ready = 1'b0;
      send_ar(32'h400, 8'd1, 3'd3, INCR, 4'h9);
      check("t5_r_valid", r_valid, 1);
      check("t5_r_data_first", r_data, 64'hAAAA_0000_0000_0400);
      wdat[0] = 64'hCCCC_0000_0000_0408;
      axi_write(32'h408, 8'd0, 3'd3, INCR, 4'h1, 0);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("t5_hold_data_%0d", k), r_data, 64'hAAAA_0000_0000_0400);
         check($sformatf("t5_hold_last_%0d", k), {r_valid, r_last}, 2'b10);
         @(negedge clk);
      end
      r_ready = 1'b1;
      recv_r(8'd1);
      check("t5_beat0", rdat[0], 64'hAAAA_0000_0000_0400);
      check("t5_beat1_new", rdat[1], 64'hCCCC_0000_0000_0408);
      check("t5_last", {rlast[0], rlast[1]}, 2'b01);

      // T6: reset in the middle of a write burst
      send_aw(32'h500, 8'd3, 3'd3, INCR, 4'h4);
      send_w(64'hE0, 8'hFF, 1'b0);
      send_w(64'hE1, 8'hFF, 1'b0);
      check("t6_mid_burst_state", dbg_w_state, 2'd1);
      rst = 1'b1;
      #1;
      check("t6_rst_readies", {aw_ready, w_ready, ar_ready}, 3'b000);
      check("t6_rst_valids", {b_valid, r_valid}, 2'b00);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      wdat[0] = 64'hF0;
      axi_write(32'h600, 8'd0, 3'd3, INCR, 4'h4, 0);
      check("t6_new_aw_resp", bresp, OKAY);
      axi_read(32'h500, 8'd1, 3'd3, INCR, 4'h4);
      check("t6_kept_beat0", rdat[0], 64'hE0);
      check("t6_kept_beat1", rdat[1], 64'hE1);
      axi_read(32'h600, 8'd0, 3'd3, INCR, 4'h4);
      check("t6_new_write", rdat[0], 64'hF0);

      // Address window edge at BASE_ADDR + 1024*8 = 0x2000
      wdat[0] = 64'h0BAD_0BAD_0BAD_0BAD;
      axi_write(32'h2008, 8'd0, 3'd3, INCR, 4'h2, 0);
`ifdef AXI_SRAM_BOUNDS_EN
      check("oob_write_resp", bresp, DECERR);
      axi_read(32'h2000, 8'd0, 3'd3, INCR, 4'h2);
      check("oob_read_resp", rresp[0], DECERR);
      check("oob_read_data", rdat[0], 64'h0);
`else
      check("alias_write_resp", bresp, OKAY);
      axi_read(32'h8, 8'd0, 3'd3, INCR, 4'h2);
      check("alias_read_data", rdat[0], 64'h0BAD_0BAD_0BAD_0BAD);
      check("alias_read_resp", rresp[0], OKAY);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
